// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for a shared memory port with timeout
module mem_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] addr0,
   input  logic [WIDTH-1:0] wdata0,
   input  logic             we0,
   output logic             ack0,
   output logic             err0,
   output logic [WIDTH-1:0] rdata0,
   input  logic             req1,
   input  logic [WIDTH-1:0] addr1,
   input  logic [WIDTH-1:0] wdata1,
   input  logic             we1,
   output logic             ack1,
   output logic             err1,
   output logic [WIDTH-1:0] rdata1,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_we,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             sel
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state;
   logic          last;
   logic [CW-1:0] cnt;

   logic busy;
   logic timeout;
   logic done;
   logic gnt_any;
   logic gnt_idx;

   // Completion decode: ack beats a coinciding timeout, so timeout requires !mem_ack
   always_comb begin
      busy    = (state == BUSY);
      timeout = busy && !mem_ack && (cnt == CNT_LAST);
      done    = (busy && mem_ack) || timeout;
      ack0    = busy && !sel && mem_ack;
      ack1    = busy &&  sel && mem_ack;
      err0    = timeout && !sel;
      err1    = timeout &&  sel;
      rdata0  = ack0 ? mem_rdata : '0;
      rdata1  = ack1 ? mem_rdata : '0;
   end

   // Grant selection: ties in IDLE go to the requester not served last;
   // at the end of a transaction only the other requester may chain in
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = 1'b0;
      if (state == IDLE) begin
         if (req0 && req1) begin
            gnt_any = 1'b1;
            gnt_idx = ~last;
         end else if (req0 || req1) begin
            gnt_any = 1'b1;
            gnt_idx = req1;
         end
      end else if (done) begin
         if (sel ? req0 : req1) begin
            gnt_any = 1'b1;
            gnt_idx = ~sel;
         end
      end
   end

   // FSM with registered port outputs; request fields are captured once at grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= 1'b0;
         last      <= 1'b0;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (gnt_any) begin
         state     <= BUSY;
         sel       <= gnt_idx;
         last      <= gnt_idx;
         cnt       <= '0;
         mem_req   <= 1'b1;
         mem_addr  <= gnt_idx ? addr1  : addr0;
         mem_wdata <= gnt_idx ? wdata1 : wdata0;
         mem_we    <= gnt_idx ? we1    : we0;
      end else if (busy && done) begin
         state   <= IDLE;
         cnt     <= '0;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
      end else if (busy) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: width of address, write-data and read-data buses.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles a granted transaction waits for mem_ack (TIMEOUT >= 2).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0 / req1  input  1  transaction request from requester 0 (instruction side) / 1 (data side); held high until ack or err.
REQ-006 addr0 / addr1  input  WIDTH  request address.
REQ-007 wdata0 / wdata1  input  WIDTH  write data.
REQ-008 we0 / we1  input  1  write enable (1 = write, 0 = read).
REQ-009 ack0 / ack1  output  1  one-cycle completion strobe to requester.
REQ-010 err0 / err1  output  1  one-cycle timeout strobe to requester.
REQ-011 rdata0 / rdata1  output  WIDTH  read data, valid only while matching ack is high.
REQ-012 mem_req  output  1  shared memory port request.
REQ-013 mem_addr / mem_wdata  output  WIDTH  shared port address / write data, registered.
REQ-014 mem_we  output  1  shared port write enable, registered.
REQ-015 mem_ack  input  1  memory completion strobe.
REQ-016 mem_rdata  input  WIDTH  memory read data, valid with mem_ack.
REQ-017 sel  output  1  current owner (0/1), registered; drives the select of the downstream 2:1 port multiplexers.

Function
REQ-018 The block SHALL implement two states: IDLE and BUSY.
REQ-019 In IDLE, if exactly one reqN is high at a rising edge, the block SHALL enter BUSY, set sel=N, and capture addrN, wdataN and weN into mem_addr, mem_wdata and mem_we.
REQ-020 If req0 and req1 are both high in IDLE, the block SHALL grant the requester not recorded in register last; after reset, last=0, so the first tie grants requester 1.
REQ-021 On every grant, last SHALL be updated to the granted index.
REQ-022 mem_req SHALL equal 1 exactly while in BUSY; request-to-mem_req latency is one cycle.
REQ-023 In IDLE, mem_we SHALL be forced to 0; mem_addr and mem_wdata SHALL hold their last captured values.
REQ-024 ackN SHALL be combinational: ackN = BUSY && sel==N && mem_ack; rdataN = mem_rdata when ackN is high, else 0.
REQ-025 A timeout counter cnt (width ceil(log2(TIMEOUT))) SHALL clear on entry to BUSY and increment on each BUSY cycle without mem_ack.
REQ-026 In a BUSY cycle with cnt==TIMEOUT-1 and mem_ack=0, errN (N=sel) SHALL be 1 for that cycle only, and rdataN SHALL be 0.
REQ-027 If mem_ack and the timeout condition coincide, the ack SHALL win: ackN=1 and errN=0.
REQ-028 At the edge ending a BUSY cycle with ack or err: if the other requester's req is high, the block SHALL re-enter BUSY granting it, with a fresh capture and cnt=0 (back-to-back, no IDLE cycle); otherwise it SHALL go to IDLE.
REQ-029 mem_ack received in IDLE SHALL be ignored; no ack or err is produced.
REQ-030 Changes on addrN, wdataN or weN after the grant SHALL NOT affect the mem_* outputs of the transaction in progress.
REQ-031 ack and err SHALL never be asserted for both requesters in the same cycle.

Reset
REQ-032 While rst=1, the block SHALL hold: state=IDLE, sel=0, last=0, cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all ackN, errN and rdataN = 0.
REQ-033 Asserting rst in BUSY SHALL abort the transaction immediately, without a clock edge; no ack or err is issued for it.

Verification
REQ-034 req0 only, addr0=0x100, we0=0; mem_ack high 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> sel=0, mem_addr=0x100, ack0 one cycle with rdata0=0xDEADBEEF, state returns to IDLE.
REQ-035 req0 and req1 both raised in the same cycle after reset -> requester 1 is granted first, then requester 0 is granted back-to-back on the edge after ack1, with no idle cycle.
REQ-036 req1 write, addr1=0x40, wdata1=0x12345678, with mem_ack never asserted -> err1 pulses in the 16th BUSY cycle, ack1 stays 0, state returns to IDLE.
REQ-037 mem_ack asserted in the same cycle as cnt==15 -> ack high, err low.
REQ-038 rst pulsed mid-BUSY -> mem_req drops asynchronously, all outputs are 0, and no ack or err is issued.
REQ-039 mem_ack pulsed while IDLE with no requests -> ack0, ack1, err0 and err1 all remain 0.
